// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_DONE
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, glitch filter and falling-edge pulse for one PS/2 line.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic fall
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          filt_q;
  logic          filt_d1_q;
  logic [FW-1:0] cnt_q;

  // Filtered level only follows the synchronized line after FILTER_LEN
  // consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '1;
      filt_q    <= 1'b1;
      filt_d1_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], din};
      filt_d1_q <= filt_q;
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == F_LAST) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sync_out = sync_q[1];
  assign fall     = filt_d1_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data bits, odd parity, stop, ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_clk_w,
  input  logic       ps2_data_i,
  output logic       ps2_data_o,
  output logic       ps2_data_w,
  input  logic       rx_busy,
  input  logic       send_req,
  input  logic [7:0] send_data,
  output logic       send_idle
);

  localparam int unsigned CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

  ps2_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          data_bit_q, data_bit_d;
  logic [1:0]    data_sync_q;
  logic          clk_sync;
  logic          clk_fall;
  logic          data_sync;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .rst      (rst),
    .din      (ps2_clk_i),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  assign data_sync = data_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cyc_q       <= '0;
      tmo_q       <= '0;
      data_bit_q  <= 1'b1;
      data_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_q       <= cyc_d;
      tmo_q       <= tmo_d;
      data_bit_q  <= data_bit_d;
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cyc_d      = cyc_q;
    data_bit_d = data_bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (send_req && !rx_busy) begin
          state_d    = ST_INHIBIT;
          shift_d    = send_data;
          bit_cnt_d  = '0;
          cyc_d      = '0;
          data_bit_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (cyc_q == INH_LAST) state_d = ST_START;
        else                   cyc_d   = cyc_q + 1'b1;
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        if (clk_fall) begin
          data_bit_d = shift_q[bit_cnt_q[2:0]];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == DATA_LAST) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          data_bit_d = odd_parity(shift_q);
          bit_cnt_d  = bit_cnt_q + 4'd1;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          data_bit_d = 1'b1;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          state_d    = ST_ACK;
        end
      end
      // A missing acknowledge is not an error: the frame completes either way.
      ST_ACK: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (clk_sync && data_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_ACK}) &&
        (tmo_q == TMO_LAST)) begin
      state_d    = ST_IDLE;
      data_bit_d = 1'b1;
    end

    // Timeout window restarts on every device clock edge and every state change.
    if (clk_fall || (state_d != state_q) || (state_q == ST_IDLE)) tmo_d = '0;
    else                                                           tmo_d = tmo_q + 1'b1;
  end

  assign ps2_clk_w  = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_clk_o  = 1'b0;
  assign ps2_data_w = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign ps2_data_o = ps2_data_w ? data_bit_q : 1'b1;
  assign send_idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model on open-drain, pulled-up lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 50;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned FILT = 4;
  localparam int          HALF = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_o, ps2_clk_w, ps2_data_o, ps2_data_w;
  logic       rx_busy, send_req, send_idle;
  logic [7:0] send_data;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  int tests = 0;
  int fails = 0;

  assign clk_line  = !(ps2_clk_w && !ps2_clk_o) && !dev_clk_low;
  assign data_line = !(ps2_data_w && !ps2_data_o) && !dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (clk_line),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_clk_w  (ps2_clk_w),
    .ps2_data_i (data_line),
    .ps2_data_o (ps2_data_o),
    .ps2_data_w (ps2_data_w),
    .rx_busy    (rx_busy),
    .send_req   (send_req),
    .send_data  (send_data),
    .send_idle  (send_idle)
  );

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic pulse_req(input logic [7:0] d);
    @(posedge clk); #1;
    send_data = d;
    send_req  = 1'b1;
    @(posedge clk); #1;
    send_req  = 1'b0;
  endtask

  task automatic device_receive(input bit do_ack, output logic [7:0] rx, output logic par,
                                output logic stp, output int low_cyc, output logic start_ok);
    logic [9:0] bits;
    int n;
    bits = '0; rx = '0; par = 1'b0; stp = 1'b0; low_cyc = 0; start_ok = 1'b0;
    n = 0;
    while (clk_line && n < 1000) begin @(posedge clk); #1; n++; end
    if (clk_line) begin
      check("inhibit_seen", clk_line, 0);
      return;
    end
    while (!clk_line && low_cyc < int'(INH) * 4) begin @(posedge clk); #1; low_cyc++; end
    start_ok = !data_line;
    #HALF;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      #HALF;
      dev_clk_low = 1'b0;
      #1;
      if (k <= 10) bits[k-1] = data_line;
      #(HALF - 1);
    end
    dev_data_low = 1'b0;
    rx  = bits[7:0];
    par = bits[8];
    stp = bits[9];
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (!send_idle && n < limit) begin @(posedge clk); #1; n++; end
    check(name, send_idle, 1);
  endtask

  task automatic do_frame(input logic [7:0] d, input bit ack, input logic exp_par);
    logic [7:0] rx;
    logic par, stp, start_ok;
    int low;
    pulse_req(d);
    check("busy_after_accept", send_idle, 0);
    device_receive(ack, rx, par, stp, low, start_ok);
    check("inhibit_min", (low >= int'(INH)), 1);
    check("inhibit_max", (low <= int'(INH) + 5), 1);
    check("start_bit", start_ok, 1);
    check("rx_byte", rx, d);
    check("parity", par, exp_par);
    check("stop_bit", stp, 1);
    wait_idle("idle_after_frame", 200);
    check("clk_released", ps2_clk_w, 0);
    check("data_released", ps2_data_w, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    logic drove, lost_idle;
    logic [7:0] d;
    bit ack;
    int n;

    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h7E, 1'b0, 1'b1};

    rst = 1'b0; send_req = 1'b0; send_data = '0; rx_busy = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    #23;
    check("rst_clk_w", ps2_clk_w, 0);
    check("rst_clk_o", ps2_clk_o, 0);
    check("rst_data_w", ps2_data_w, 0);
    check("rst_data_o", ps2_data_o, 1);
    check("rst_idle", send_idle, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    foreach (vecs[i]) do_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_par);

    // rx_busy blocks and drops requests
    rx_busy = 1'b1;
    drove = 1'b0; lost_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      send_data = 8'h3C;
      send_req  = (i % 3 == 0);
      drove     = drove | ps2_clk_w | ps2_data_w;
      lost_idle = lost_idle | !send_idle;
    end
    send_req = 1'b0;
    rx_busy  = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      drove     = drove | ps2_clk_w | ps2_data_w;
      lost_idle = lost_idle | !send_idle;
    end
    check("busy_no_drive", drove, 0);
    check("busy_stays_idle", lost_idle, 0);
    do_frame(8'h3C, 1'b1, 1'b1);

    // reset in the middle of the data bits
    pulse_req(8'h96);
    n = 0;
    while (!clk_line && n < 200) begin @(posedge clk); #1; n++; end
    check("midrst_released", clk_line, 1);
    #HALF;
    repeat (4) begin
      dev_clk_low = 1'b1; #HALF;
      dev_clk_low = 1'b0; #HALF;
    end
    dev_clk_low = 1'b1;
    #100;
    check("midrst_bit4_drive", ps2_data_w, 1);
    check("midrst_bit4_value", ps2_data_o, 1);
    rst = 1'b0;
    #1;
    check("midrst_clk_w", ps2_clk_w, 0);
    check("midrst_data_w", ps2_data_w, 0);
    check("midrst_idle_in_rst", send_idle, 1);
    #99;
    dev_clk_low = 1'b0;
    #100;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle_after", send_idle, 1);
    do_frame(8'h5A, 1'b1, 1'b1);

    // device never clocks: timeout releases the bus
    pulse_req(8'h77);
    n = 0;
    while (!clk_line && n < 200) begin @(posedge clk); #1; n++; end
    check("tmo_clk_released", clk_line, 1);
    check("tmo_data_held", ps2_data_w, 1);
    n = 0;
    while (!send_idle && n < int'(TMO) + 200) begin @(posedge clk); #1; n++; end
    check("tmo_idle", send_idle, 1);
    check("tmo_not_early", (n >= int'(TMO) - 5), 1);
    check("tmo_not_late", (n <= int'(TMO) + 5), 1);
    check("tmo_data_w", ps2_data_w, 0);
    check("tmo_clk_w", ps2_clk_w, 0);

    // randomized bytes against the parity model
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      ack = bit'($urandom_range(0, 1));
      do_frame(d, ack, model_parity(d));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
